rob_multi: RTL and testbench

- Parametrised reorder buffer for the multi-issue core. Successor to the fixed 16-entry, 3-lane, 2-writeback ROB.
- Allocates entries in program order for up to DW renamed instructions per cycle and accepts results from WB execution ports.
- Retires up to CW completed instructions per cycle in order, returning old and new physical tags to rename/free-list.
- Adds: occupancy count, exception-at-head detection with precise self-flush, and per-entry result data on commit.

---
 rtl/rob_multi.sv | 150 +++++++++++++++
 tb/tb_rob_multi.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi.sv
// rob_multi: parametrised reorder buffer for the multi-issue core.
// In-order allocate/commit, out-of-order writeback, precise exception flush.
module rob_multi #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int DW     = 3,
    parameter int WB     = 2,
    parameter int CW     = 3,
    parameter int PREG_W = 5,
    parameter int DATA_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_freeze_front,
    input  logic [DW-1:0]        i_alloc_valid,
    input  logic [DW-1:0]        i_alloc_regwr,
    input  logic [DW*PREG_W-1:0] i_alloc_pw,
    input  logic [DW*PREG_W-1:0] i_alloc_pw_old,
    output logic [DW*TAG_W-1:0]  o_alloc_tag,
    output logic                 o_full_rob,
    output logic [TAG_W:0]       o_rob_count,
    input  logic [WB-1:0]        i_wb_valid,
    input  logic [WB*TAG_W-1:0]  i_wb_tag,
    input  logic [WB*DATA_W-1:0] i_wb_data,
    input  logic [WB-1:0]        i_wb_exp,
    output logic [CW-1:0]        o_commit_valid,
    output logic [CW-1:0]        o_commit_regwr,
    output logic [CW*PREG_W-1:0] o_commit_pw,
    output logic [CW*PREG_W-1:0] o_commit_pw_old,
    output logic [CW*DATA_W-1:0] o_commit_data,
    output logic                 o_exc_valid,
    output logic [TAG_W-1:0]     o_exc_tag
);

    localparam logic [TAG_W:0] FULL_LIM = (TAG_W+1)'(DEPTH - DW);

    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_done;
    logic [DEPTH-1:0]  r_exp;
    logic [DEPTH-1:0]  r_regwr;
    logic [PREG_W-1:0] r_pw     [DEPTH];
    logic [PREG_W-1:0] r_pw_old [DEPTH];
    logic [DATA_W-1:0] r_data   [DEPTH];

    logic              w_exc;
    logic              w_alloc_fire;
    logic [TAG_W:0]    w_alloc_n;
    logic [TAG_W:0]    w_commit_n;
    logic [DEPTH-1:0]  w_wb_hit;
    logic [DEPTH-1:0]  w_wb_exp;
    logic [DATA_W-1:0] w_wb_data [DEPTH];

    // Exception detect, occupancy, allocation gating and tags.
    always_comb begin
        w_exc       = r_busy[r_head] & r_done[r_head] & r_exp[r_head];
        o_exc_valid = w_exc;
        o_exc_tag   = r_head;
        o_rob_count = r_count;
        o_full_rob  = r_count > FULL_LIM;
        w_alloc_fire = (|i_alloc_valid) & ~i_freeze_front & ~o_full_rob
                     & ~i_flush & ~w_exc;
        w_alloc_n = '0;
        for (int i = 0; i < DW; i++) begin
            o_alloc_tag[i*TAG_W +: TAG_W] = r_tail + TAG_W'(i);
            if (w_alloc_fire && i_alloc_valid[i])
                w_alloc_n = w_alloc_n + 1'b1;
        end
    end

    // In-order retire window: stops at first unfinished or excepting entry.
    always_comb begin
        logic             run;
        logic [TAG_W-1:0] idx;
        run        = 1'b1;
        w_commit_n = '0;
        for (int j = 0; j < CW; j++) begin
            idx = r_head + TAG_W'(j);
            run = run & r_busy[idx] & r_done[idx] & ~r_exp[idx];
            o_commit_valid[j] = run & ~i_flush & ~w_exc;
            o_commit_regwr[j] = r_regwr[idx];
            o_commit_pw[j*PREG_W +: PREG_W]     = r_pw[idx];
            o_commit_pw_old[j*PREG_W +: PREG_W] = r_pw_old[idx];
            o_commit_data[j*DATA_W +: DATA_W]   = r_data[idx];
            if (o_commit_valid[j])
                w_commit_n = w_commit_n + 1'b1;
        end
    end

    // Writeback merge per entry: exp ORed, highest port supplies data.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_wb_hit[e]  = 1'b0;
            w_wb_exp[e]  = 1'b0;
            w_wb_data[e] = r_data[e];
            for (int k = 0; k < WB; k++) begin
                if (i_wb_valid[k] && r_busy[e] &&
                    i_wb_tag[k*TAG_W +: TAG_W] == TAG_W'(e)) begin
                    w_wb_hit[e]  = 1'b1;
                    w_wb_exp[e]  = w_wb_exp[e] | i_wb_exp[k];
                    w_wb_data[e] = i_wb_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // State update: reset/flush/self-flush, else writeback, retire, allocate.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush || w_exc) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_busy  <= '0;
            r_done  <= '0;
            r_exp   <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_wb_hit[e]) begin
                    r_done[e] <= 1'b1;
                    r_exp[e]  <= w_wb_exp[e];
                    r_data[e] <= w_wb_data[e];
                end
            end
            for (int j = 0; j < CW; j++) begin
                if (o_commit_valid[j]) begin
                    r_busy[r_head + TAG_W'(j)] <= 1'b0;
                    r_done[r_head + TAG_W'(j)] <= 1'b0;
                    r_exp[r_head + TAG_W'(j)]  <= 1'b0;
                end
            end
            for (int i = 0; i < DW; i++) begin
                if (w_alloc_fire && i_alloc_valid[i]) begin
                    r_busy[r_tail + TAG_W'(i)]   <= 1'b1;
                    r_done[r_tail + TAG_W'(i)]   <= 1'b0;
                    r_exp[r_tail + TAG_W'(i)]    <= 1'b0;
                    r_regwr[r_tail + TAG_W'(i)]  <= i_alloc_regwr[i];
                    r_pw[r_tail + TAG_W'(i)]     <= i_alloc_pw[i*PREG_W +: PREG_W];
                    r_pw_old[r_tail + TAG_W'(i)] <= i_alloc_pw_old[i*PREG_W +: PREG_W];
                end
            end
            r_head  <= r_head + w_commit_n[TAG_W-1:0];
            r_tail  <= r_tail + w_alloc_n[TAG_W-1:0];
            r_count <= r_count + w_alloc_n - w_commit_n;
        end
    end

endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi: randomized bench for rob_multi.
// Reference is a queue of in-flight instructions in program order.
module tb_rob_multi;

    localparam int DEPTH  = 16;
    localparam int TAG_W  = 4;
    localparam int DW     = 3;
    localparam int WB     = 2;
    localparam int CW     = 3;
    localparam int PREG_W = 5;
    localparam int DATA_W = 16;
    localparam int NCYC   = 4000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 freeze_front;
    logic [DW-1:0]        alloc_valid;
    logic [DW-1:0]        alloc_regwr;
    logic [DW*PREG_W-1:0] alloc_pw;
    logic [DW*PREG_W-1:0] alloc_pw_old;
    logic [DW*TAG_W-1:0]  alloc_tag;
    logic                 full_rob;
    logic [TAG_W:0]       rob_count;
    logic [WB-1:0]        wb_valid;
    logic [WB*TAG_W-1:0]  wb_tag;
    logic [WB*DATA_W-1:0] wb_data;
    logic [WB-1:0]        wb_exp;
    logic [CW-1:0]        commit_valid;
    logic [CW-1:0]        commit_regwr;
    logic [CW*PREG_W-1:0] commit_pw;
    logic [CW*PREG_W-1:0] commit_pw_old;
    logic [CW*DATA_W-1:0] commit_data;
    logic                 exc_valid;
    logic [TAG_W-1:0]     exc_tag;

    rob_multi #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .DW(DW), .WB(WB),
        .CW(CW), .PREG_W(PREG_W), .DATA_W(DATA_W)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_freeze_front(freeze_front),
        .i_alloc_valid(alloc_valid), .i_alloc_regwr(alloc_regwr),
        .i_alloc_pw(alloc_pw), .i_alloc_pw_old(alloc_pw_old),
        .o_alloc_tag(alloc_tag), .o_full_rob(full_rob),
        .o_rob_count(rob_count),
        .i_wb_valid(wb_valid), .i_wb_tag(wb_tag),
        .i_wb_data(wb_data), .i_wb_exp(wb_exp),
        .o_commit_valid(commit_valid), .o_commit_regwr(commit_regwr),
        .o_commit_pw(commit_pw), .o_commit_pw_old(commit_pw_old),
        .o_commit_data(commit_data),
        .o_exc_valid(exc_valid), .o_exc_tag(exc_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              regwr;
        logic [PREG_W-1:0] pw;
        logic [PREG_W-1:0] pwo;
        logic              done;
        logic              exp;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t q[$];
    int   mhead;
    int   m_cn;
    bit   m_exc;
    bit   m_fire;
    int   n_chk;
    int   n_fail;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int  sz;
        bit  full;
        sz    = q.size();
        full  = (DEPTH - sz) < DW;
        m_exc = (sz > 0) && q[0].done && q[0].exp;
        chk("rob_count", 64'(rob_count), 64'(sz));
        chk("full_rob", 64'(full_rob), 64'(full));
        chk("exc_valid", 64'(exc_valid), 64'(m_exc));
        if (m_exc)
            chk("exc_tag", 64'(exc_tag), 64'(mhead));
        m_cn = 0;
        if (!flush && !m_exc)
            while (m_cn < CW && m_cn < sz && q[m_cn].done && !q[m_cn].exp)
                m_cn++;
        chk("commit_valid", 64'(commit_valid), 64'((1 << m_cn) - 1));
        for (int j = 0; j < m_cn; j++) begin
            chk("commit_regwr", 64'(commit_regwr[j]), 64'(q[j].regwr));
            chk("commit_pw", 64'(commit_pw[j*PREG_W +: PREG_W]), 64'(q[j].pw));
            chk("commit_pw_old", 64'(commit_pw_old[j*PREG_W +: PREG_W]),
                64'(q[j].pwo));
            chk("commit_data", 64'(commit_data[j*DATA_W +: DATA_W]),
                64'(q[j].data));
        end
        for (int i = 0; i < DW; i++)
            chk("alloc_tag", 64'(alloc_tag[i*TAG_W +: TAG_W]),
                64'((mhead + sz + i) % DEPTH));
        m_fire = (|alloc_valid) && !freeze_front && !full && !flush && !m_exc;
    endtask

    task automatic update_model();
        bit   hit [DEPTH];
        int   sz;
        int   pos;
        ent_t e;
        sz = q.size();
        if (rst || flush || m_exc) begin
            q.delete();
            mhead = 0;
            return;
        end
        for (int p = 0; p < DEPTH; p++) hit[p] = 1'b0;
        for (int k = 0; k < WB; k++) begin
            if (wb_valid[k]) begin
                pos = (int'(wb_tag[k*TAG_W +: TAG_W]) - mhead + DEPTH) % DEPTH;
                if (pos < sz) begin
                    q[pos].done = 1'b1;
                    q[pos].exp  = hit[pos] ? (q[pos].exp | wb_exp[k]) : wb_exp[k];
                    q[pos].data = wb_data[k*DATA_W +: DATA_W];
                    hit[pos]    = 1'b1;
                end
            end
        end
        for (int j = 0; j < m_cn; j++) void'(q.pop_front());
        mhead = (mhead + m_cn) % DEPTH;
        if (m_fire) begin
            for (int i = 0; i < DW; i++) begin
                if (alloc_valid[i]) begin
                    e.regwr = alloc_regwr[i];
                    e.pw    = alloc_pw[i*PREG_W +: PREG_W];
                    e.pwo   = alloc_pw_old[i*PREG_W +: PREG_W];
                    e.done  = 1'b0;
                    e.exp   = 1'b0;
                    e.data  = '0;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic drive(input int cyc);
        int phase;
        int na;
        int wrate;
        int sz;
        phase = (cyc / 150) % 3;
        sz    = q.size();
        rst   = (cyc == NCYC / 2);
        flush = ($urandom_range(0, 79) == 0);
        freeze_front = ($urandom_range(0, 7) == 0);
        na = (phase == 2) ? $urandom_range(0, 1) : $urandom_range(0, DW);
        alloc_valid  = DW'((1 << na) - 1);
        alloc_regwr  = DW'($urandom);
        alloc_pw     = (DW*PREG_W)'($urandom);
        alloc_pw_old = (DW*PREG_W)'($urandom);
        wrate = (phase == 0) ? 10 : (phase == 1) ? 55 : 90;
        for (int k = 0; k < WB; k++) begin
            wb_valid[k] = ($urandom_range(0, 99) < wrate);
            wb_exp[k]   = ($urandom_range(0, 39) == 0);
            wb_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
            if (k > 0 && wb_valid[0] && $urandom_range(0, 5) == 0)
                wb_tag[k*TAG_W +: TAG_W] = wb_tag[0 +: TAG_W];
            else if (sz > 0 && $urandom_range(0, 9) != 0)
                wb_tag[k*TAG_W +: TAG_W] =
                    TAG_W'((mhead + $urandom_range(0, sz - 1)) % DEPTH);
            else
                wb_tag[k*TAG_W +: TAG_W] = TAG_W'($urandom);
        end
        assert ((alloc_valid & (alloc_valid + 1'b1)) == '0)
            else $error("alloc_valid not packed");
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        mhead = 0;
        m_cn = 0;
        m_exc = 1'b0;
        m_fire = 1'b0;
        rst = 1'b1;
        flush = 1'b0;
        freeze_front = 1'b0;
        alloc_valid = '0;
        alloc_regwr = '0;
        alloc_pw = '0;
        alloc_pw_old = '0;
        wb_valid = '0;
        wb_tag = '0;
        wb_data = '0;
        wb_exp = '0;
        repeat (2) @(posedge clk);
        update_model();
        #1;
        rst = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            drive(c);
            #1;
            check_outputs();
            @(posedge clk);
            update_model();
            #1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
